// File: rtl/fpio_fifo_in_client_if.sv
// Handshake bundle for the fpio FIFO read client: FIFO-side request/ack plus
// the consumer-side valid/ready port. master = client, slave = FIFO/consumer.
interface fpio_fifo_in_client_if #(
   parameter int FIFO_BITS  = 16,
   parameter int DATA_WIDTH = 8
);
   logic [FIFO_BITS-1:0]  avail;
   logic [DATA_WIDTH-1:0] data;
   logic                  data_en;
   logic                  data_ack;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      input  avail, data, data_ack, out_ready,
      output data_en, out_data, out_valid
   );

   modport slave (
      output avail, data, data_ack, out_ready,
      input  data_en, out_data, out_valid
   );
endinterface

// File: rtl/fpio_fifo_in_client.sv
// Drains an fpio FIFO one word per request into a small circular buffer that
// feeds a valid/ready consumer; tracks a sticky ack-timeout and a word count.
module fpio_fifo_in_client #(
   parameter int FIFO_BITS   = 16,
   parameter int DATA_WIDTH  = 8,
   parameter int BUF_DEPTH   = 4,
   parameter int ACK_TIMEOUT = 256
) (
   input  logic                         clk,
   input  logic                         rstn,
   fpio_fifo_in_client_if.master        bus,
   input  logic                         clr_err,
   output logic                         err_timeout,
   output logic [31:0]                  rd_count,
   output logic [$clog2(BUF_DEPTH):0]   buf_count
);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0] TLAST = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t                r_state, w_nstate;
   logic [TW-1:0]         r_tcnt;
   logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
   logic [PW-1:0]         r_wptr, r_rptr;
   logic [CW-1:0]         r_cnt;
   logic                  r_err;
   logic [31:0]           r_rd;
   logic                  w_issue, w_push, w_pop, w_tmo;

   // State register
   always_ff @(posedge clk) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_nstate;
   end

   // Next state
   always_comb begin
      w_nstate = r_state;
      case (r_state)
         S_IDLE:  if (w_issue) w_nstate = S_REQ;
         S_REQ:   if (bus.data_ack || w_tmo) w_nstate = S_IDLE;
         default: w_nstate = S_IDLE;
      endcase
   end

   // Outputs / per-cycle events; issue only with a guaranteed free slot
   always_comb begin
      w_issue = 1'b0;
      w_push  = 1'b0;
      w_tmo   = 1'b0;
      case (r_state)
         S_IDLE: w_issue = (bus.avail != FIFO_BITS'(0)) && (r_cnt < CW'(BUF_DEPTH));
         S_REQ: begin
            w_push = bus.data_ack;
            w_tmo  = !bus.data_ack && (ACK_TIMEOUT != 0) && (r_tcnt == TLAST);
         end
         default: ;
      endcase
   end

   assign w_pop         = (r_cnt != '0) && bus.out_ready;
   assign bus.data_en   = (r_state == S_REQ);
   assign bus.out_valid = (r_cnt != '0);
   assign bus.out_data  = r_mem[r_rptr];
   assign err_timeout   = r_err;
   assign rd_count      = r_rd;
   assign buf_count     = r_cnt;

   // Timeout counter restarts from zero every time a request is issued
   always_ff @(posedge clk) begin
      if (!rstn || r_state != S_REQ) r_tcnt <= '0;
      else                           r_tcnt <= r_tcnt + TW'(1);
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= bus.data;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         r_rd   <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
            r_rd   <= r_rd + 32'd1;
         end
         if (w_pop) r_rptr <= r_rptr + PW'(1);
         if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
         else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
         if (w_tmo)        r_err <= 1'b1;
         else if (clr_err) r_err <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fpio_fifo_in_client.sv
// Randomized bench: an fpio FIFO responder drives the client, and a cycle
// reference model of the request/buffer rules scores every observable output.
module tb_fpio_fifo_in_client;
   localparam int FB = 16, DW = 8, BD = 4, TO = 8;
   localparam int M_MANUAL = 0, M_IMM = 1, M_NEVER = 2, M_RAND = 3;

   logic                  clk = 1'b0;
   logic                  rstn;
   logic                  clr_err;
   logic                  err_timeout;
   logic [31:0]           rd_count;
   logic [$clog2(BD):0]   buf_count;

   fpio_fifo_in_client_if #(.FIFO_BITS(FB), .DATA_WIDTH(DW)) bus ();

   fpio_fifo_in_client #(.FIFO_BITS(FB), .DATA_WIDTH(DW), .BUF_DEPTH(BD), .ACK_TIMEOUT(TO)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .bus         (bus.master),
      .clr_err     (clr_err),
      .err_timeout (err_timeout),
      .rd_count    (rd_count),
      .buf_count   (buf_count)
   );

   always #5 clk = ~clk;

   int errs = 0, checks = 0;
   int mode = M_MANUAL;
   logic [DW-1:0] src [$];

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // FIFO endpoint: avail tracks the words left in src, one word per ack
   always @(posedge clk) begin
      #1;
      if (mode != M_MANUAL) begin
         bus.data_ack = 1'b0;
         bus.data     = DW'($urandom);
         if (mode == M_IMM)  bus.data_ack = bus.data_en && (src.size() != 0);
         if (mode == M_RAND) bus.data_ack = ($urandom_range(0, 1) == 1) && (!bus.data_en || src.size() != 0);
         if (bus.data_ack && bus.data_en) bus.data = src.pop_front();
         bus.avail = FB'(src.size());
      end
   end

   // Reference model: request open/close rules, FIFO of expected words
   bit            m_known = 0, m_en = 0, m_err = 0;
   int            m_run = 0;
   logic [31:0]   m_rd = 0;
   logic [DW-1:0] m_q [$];

   always @(negedge clk) begin
      int  sz;
      bit  fire;
      if (m_known) begin
         chk("data_en", bus.data_en, m_en);
         chk("out_valid", bus.out_valid, m_q.size() != 0);
         chk("buf_count", buf_count, m_q.size());
         chk("rd_count", rd_count, m_rd);
         chk("err_timeout", err_timeout, m_err);
         if (bus.out_valid && bus.out_ready && m_q.size() != 0)
            chk("out_data", bus.out_data, m_q[0]);
      end
      if (!rstn) begin
         m_known = 1; m_en = 0; m_err = 0; m_run = 0; m_rd = 0;
         m_q.delete();
      end else if (m_known) begin
         sz   = m_q.size();
         fire = 0;
         if (sz != 0 && bus.out_ready) void'(m_q.pop_front());
         if (m_en) begin
            if (bus.data_ack) begin
               m_q.push_back(bus.data);
               m_rd++;
               m_en = 0;
            end else if (m_run == TO - 1) begin
               fire = 1;
               m_en = 0;
            end else m_run++;
         end else if (bus.avail != 0 && sz < BD) begin
            m_en  = 1;
            m_run = 0;
         end
         if (fire) m_err = 1;
         else if (clr_err) m_err = 0;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0; clr_err = 1'b0;
      bus.avail = FB'(5); bus.data_ack = 1'b1; bus.data = '0; bus.out_ready = 1'b0;
      cyc(3);
      rstn = 1'b1; bus.data_ack = 1'b0;
      cyc(3);

      // basic stream with an always-ready consumer
      src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33);
      bus.out_ready = 1'b1; mode = M_IMM;
      cyc(12);

      // backpressure: buffer fills to depth, then single pops
      bus.out_ready = 1'b0;
      for (int i = 0; i < 10; i++) src.push_back(DW'($urandom));
      cyc(20);
      bus.out_ready = 1'b1; cyc(1); bus.out_ready = 1'b0;
      cyc(5);
      bus.out_ready = 1'b1;
      cyc(30);

      // timeout, clear, and a late ack with nothing requested
      mode = M_NEVER; src.delete(); src.push_back(8'hA5);
      cyc(12);
      clr_err = 1'b1; cyc(1); clr_err = 1'b0;
      src.delete();
      cyc(12);
      mode = M_MANUAL; bus.avail = '0; bus.data_ack = 1'b1; bus.data = 8'h5A;
      cyc(2);
      bus.data_ack = 1'b0; clr_err = 1'b1; cyc(1); clr_err = 1'b0;

      // reset while a request is outstanding with two words buffered
      bus.out_ready = 1'b0; src.push_back(8'h01); src.push_back(8'h02); mode = M_IMM;
      cyc(8);
      mode = M_NEVER; src.push_back(8'h03);
      cyc(3);
      rstn = 1'b0; cyc(1); rstn = 1'b1;
      mode = M_MANUAL; src.delete(); bus.avail = '0; bus.data_ack = 1'b1;
      cyc(2);
      bus.data_ack = 1'b0;

      // random traffic: sporadic acks, bursty consumer, occasional error clears
      mode = M_RAND;
      for (int i = 0; i < 1500; i++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0) ^ (i[8] == 1'b1);
         clr_err       = ($urandom_range(0, 31) == 0);
         if (src.size() == 0 && $urandom_range(0, 7) == 0)
            repeat ($urandom_range(1, 12)) src.push_back(DW'($urandom));
         cyc(1);
      end
      clr_err = 1'b0; bus.out_ready = 1'b1; mode = M_IMM;
      cyc(40);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/fpio_fifo_in_client.md
# fpio_fifo_in_client

Receive-side client for the fpio FIFO handshake: it drains words from an fpio FIFO endpoint, using that endpoint's `avail` count and the `data_en`/`data_ack` handshake. Received words are buffered in a small internal FIFO and presented to a local consumer over a valid/ready port. This is the read-direction counterpart of the fpio FIFO write client and sits between an fpio FIFO and testbench or RTL logic that consumes the data. It also provides a sticky handshake-timeout flag and a received-word counter.

## Interface
Parameters:
- FIFO_BITS, 16, width of the `avail` count
- DATA_WIDTH, 8, word width
- BUF_DEPTH, 4, internal buffer entries; power of 2, ≥2
- ACK_TIMEOUT, 256, maximum number of REQ cycles without `data_ack`; 0 disables the timeout

Ports (reset rstn, synchronous, active-low; clock clk):
- clk  in  1  clock; all logic on posedge
- rstn  in  1  synchronous active-low reset
- avail  in  FIFO_BITS  number of words readable in the FIFO; nonzero means a read may be issued
- data  in  DATA_WIDTH  FIFO read data; valid in the cycle `data_ack`=1
- data_en  out  1  read request, registered
- data_ack  in  1  read acknowledge; one word per ack
- out_data  out  DATA_WIDTH  head of the buffer (first-word fall-through)
- out_valid  out  1  buffer not empty
- out_ready  in  1  consumer accepts `out_data`
- clr_err  in  1  clears `err_timeout`
- err_timeout  out  1  sticky: a request timed out
- rd_count  out  32  count of words received; wraps
- buf_count  out  $clog2(BUF_DEPTH)+1  current buffer occupancy

## Operation
- FSM states:
  - IDLE: `data_en`=0.
    - Go to REQ when `avail`!=0 && `buf_count`<BUF_DEPTH.
    - `data_en`<=1 on the same edge.
  - REQ: `data_en`=1.
    - On a sampled `data_ack`=1:
      - push `data` into the buffer;
      - `rd_count`++;
      - `data_en`<=0;
      - go to IDLE.
    - Else, if ACK_TIMEOUT!=0 and the timeout counter reaches ACK_TIMEOUT:
      - `data_en`<=0;
      - `err_timeout`<=1;
      - go to IDLE;
      - no push.
- Only one request is ever outstanding.
- The issue check guarantees a free slot at push time. A push into a full buffer is impossible by construction.
- Timeout counter: cleared on entry to REQ, increments each REQ cycle without ack. A timeout fires on the edge where counter==ACK_TIMEOUT-1 and there is no ack, so `data_en` is high for exactly ACK_TIMEOUT cycles.
- Buffer: circular, with write/read pointers of $clog2(BUF_DEPTH) bits that wrap naturally.
  - `out_valid` = (`buf_count`!=0).
  - `out_data` = mem[rd_ptr].
  - Pop when `out_valid`&&`out_ready`.
  - `out_ready` while empty has no effect.
- Simultaneous push and pop: both pointers advance and `buf_count` is unchanged. This is legal even when the buffer is full, since the push is ack-driven and the slot was reserved at issue.
- `data_ack` sampled in IDLE is ignored: no push, no count.
- `clr_err`=1 clears `err_timeout` on the next edge. If a timeout fires on the same edge, the timeout wins and the flag stays 1.
- `avail` falling to 0 while in REQ does not withdraw the request. The block waits for ack or timeout.

## Timing
- Reset values (at the first edge with `rstn`=0): state IDLE, `data_en`=0, `out_valid`=0, `buf_count`=0, `rd_count`=0, `err_timeout`=0, pointers 0, timeout counter 0. Buffer contents are don't-care.
- Issue latency: `avail`!=0 sampled at edge N gives `data_en`=1 from edge N onward, i.e. visible in cycle N+1.
- Ack capture: `data` is captured at the edge that samples `data_ack`=1. `out_valid` rises the cycle after that edge if the buffer was empty.
- `data_en` is always low for at least one cycle between requests, giving a maximum throughput of 1 word per 2 cycles.
- Reset mid-request: `data_en` drops at the reset edge and the buffer is flushed. A `data_ack` arriving after reset lands in IDLE and is ignored.
- `rd_count` wraps from 0xFFFFFFFF to 0.

## Test plan
- Reset/idle: hold `rstn`=0 for 3 cycles with `avail`=5 and `data_ack`=1 → `data_en`=0, `out_valid`=0, `rd_count`=0 throughout. After release, `data_en`=1 one cycle later.
- Basic stream: `avail`=3, FIFO acks each request the same cycle with data 0x11, 0x22, 0x33, `out_ready`=1 → consumer sees 0x11, 0x22, 0x33 in order. `data_en` toggles high/low every cycle; `rd_count`=3.
- Backpressure: BUF_DEPTH=4, `out_ready`=0, `avail`=10 → exactly 4 words read, `buf_count`=4, `data_en` stays 0. Raise `out_ready` for 1 cycle → one pop, one new request follows.
- Full with simultaneous push/pop: `buf_count`=3, one request pending, `out_ready`=1 on the ack edge → `buf_count` stays 3 and pointer wrap preserves order across index 3→0.
- Timeout: ACK_TIMEOUT=8, `avail`=1, never ack → `data_en` high exactly 8 cycles, then `err_timeout`=1 and a new request is issued. A `clr_err` pulse clears the flag. A late ack in IDLE → `rd_count` unchanged.
- Reset mid-request: assert `rstn`=0 while in REQ with `buf_count`=2 → `data_en`=0, `buf_count`=0, `out_valid`=0 at the next edge. An ack after release with `avail`=0 is ignored.
